axi_rw_arbiter: RTL and testbench

- Sits directly upstream of the AXI master bridge (axi_rw) and multiplexes two core requesters onto its single rw_* request port.
- Requester 0 is instruction fetch, which is read-only. Requester 1 is the memory stage, which reads or writes.
- Captures one request at a time into registers and holds it stable until the bridge acknowledges it. Returns the read data and a one-cycle ready pulse to the granted requester.

---
 rtl/axi_rw_arbiter_pkg.sv | 19 +
 rtl/axi_rw_arbiter_rw_req_latch.sv | 57 +++++
 rtl/axi_rw_arbiter.sv | 129 ++++++++++++
 tb/tb_axi_rw_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rw_arbiter_pkg.sv
// Shared encodings for the two-requester arbiter in front of the AXI read/write bridge.
package axi_rw_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  localparam logic RW_REQ_READ  = 1'b0;
  localparam logic RW_REQ_WRITE = 1'b1;

  // Sliced down to the strobe width by users; wide enough for 1024-bit data.
  localparam logic [127:0] FULL_STRB = '1;

endpackage

// File: rtl/axi_rw_arbiter_rw_req_latch.sv
// Grant-select mux and capture registers for the request presented to the bridge.
module axi_rw_arbiter_rw_req_latch
  import axi_rw_arbiter_pkg::*;
#(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32,
  parameter int RW_STRB_WIDTH = RW_DATA_WIDTH / 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_load,
  input  logic                     i_grant,
  input  logic [RW_ADDR_WIDTH-1:0] i_if_addr,
  input  logic                     i_mem_wen,
  input  logic [RW_ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [RW_DATA_WIDTH-1:0] i_mem_wdata,
  input  logic [RW_STRB_WIDTH-1:0] i_mem_size,
  output logic                     o_req,
  output logic [RW_ADDR_WIDTH-1:0] o_addr,
  output logic [RW_DATA_WIDTH-1:0] o_wdata,
  output logic [RW_STRB_WIDTH-1:0] o_size
);

  logic                     w_req;
  logic [RW_ADDR_WIDTH-1:0] w_addr;
  logic [RW_DATA_WIDTH-1:0] w_wdata;
  logic [RW_STRB_WIDTH-1:0] w_size;

  // Fetch is always a full-width read with no write payload.
  always_comb begin
    w_req   = RW_REQ_READ;
    w_addr  = i_if_addr;
    w_wdata = '0;
    w_size  = FULL_STRB[RW_STRB_WIDTH-1:0];
    if (i_grant == GRANT_MEM) begin
      w_req   = i_mem_wen;
      w_addr  = i_mem_addr;
      w_wdata = i_mem_wdata;
      w_size  = i_mem_size;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_req   <= RW_REQ_READ;
      o_addr  <= '0;
      o_wdata <= '0;
      o_size  <= '0;
    end else if (i_load) begin
      o_req   <= w_req;
      o_addr  <= w_addr;
      o_wdata <= w_wdata;
      o_size  <= w_size;
    end
  end

endmodule

// File: rtl/axi_rw_arbiter.sv
// Arbitrates instruction fetch and memory stage onto the single rw_* port of the AXI bridge,
// one transaction at a time, and returns a one-cycle ready pulse with data to the winner.
module axi_rw_arbiter
  import axi_rw_arbiter_pkg::*;
#(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32,
  parameter int RW_STRB_WIDTH = RW_DATA_WIDTH / 8,
  parameter int ROUND_ROBIN   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_valid_i,
  input  logic [RW_ADDR_WIDTH-1:0] if_addr_i,
  output logic                     if_ready_o,
  output logic [RW_DATA_WIDTH-1:0] if_data_o,
  input  logic                     mem_valid_i,
  input  logic                     mem_wen_i,
  input  logic [RW_ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [RW_DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [RW_STRB_WIDTH-1:0] mem_size_i,
  output logic                     mem_ready_o,
  output logic [RW_DATA_WIDTH-1:0] mem_rdata_o,
  output logic                     rw_valid_o,
  output logic                     rw_req_o,
  output logic [RW_ADDR_WIDTH-1:0] rw_addr_o,
  output logic [RW_DATA_WIDTH-1:0] rw_w_data_o,
  output logic [RW_STRB_WIDTH-1:0] rw_size_o,
  input  logic                     rw_ready_i,
  input  logic [RW_DATA_WIDTH-1:0] rw_data_read_i,
  output logic [1:0]               dbg_state_o
);

  // Handshake: a requester holds valid and its fields until its ready pulses for one cycle;
  // rw_valid_o stays high with frozen fields until the bridge returns a one-cycle rw_ready_i.

  state_t                   r_state;
  logic                     r_grant;
  logic                     r_last_grant;
  logic                     r_rw_valid;
  logic                     r_if_ready;
  logic                     r_mem_ready;
  logic [RW_DATA_WIDTH-1:0] r_if_data;
  logic [RW_DATA_WIDTH-1:0] r_mem_rdata;

  logic w_any_valid;
  logic w_grant;
  logic w_accept;

  always_comb begin
    w_any_valid = if_valid_i | mem_valid_i;
    if (if_valid_i && mem_valid_i)
      w_grant = (ROUND_ROBIN != 0) ? ~r_last_grant : GRANT_MEM;
    else
      w_grant = mem_valid_i ? GRANT_MEM : GRANT_IF;
  end

  assign w_accept = (r_state == ST_IDLE) && w_any_valid;

  axi_rw_arbiter_rw_req_latch #(
    .RW_DATA_WIDTH (RW_DATA_WIDTH),
    .RW_ADDR_WIDTH (RW_ADDR_WIDTH),
    .RW_STRB_WIDTH (RW_STRB_WIDTH)
  ) u_req_latch (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_load      (w_accept),
    .i_grant     (w_grant),
    .i_if_addr   (if_addr_i),
    .i_mem_wen   (mem_wen_i),
    .i_mem_addr  (mem_addr_i),
    .i_mem_wdata (mem_wdata_i),
    .i_mem_size  (mem_size_i),
    .o_req       (rw_req_o),
    .o_addr      (rw_addr_o),
    .o_wdata     (rw_w_data_o),
    .o_size      (rw_size_o)
  );

  // RESP keeps a still-high requester valid from being re-accepted alongside its ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= GRANT_IF;
      r_last_grant <= GRANT_IF;
      r_rw_valid   <= 1'b0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            r_rw_valid   <= 1'b1;
            r_state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (rw_ready_i) begin
            r_rw_valid <= 1'b0;
            r_state    <= ST_RESP;
            if (r_grant == GRANT_MEM) begin
              r_mem_rdata <= rw_data_read_i;
              r_mem_ready <= 1'b1;
            end else begin
              r_if_data  <= rw_data_read_i;
              r_if_ready <= 1'b1;
            end
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rw_valid_o  = r_rw_valid;
  assign if_ready_o  = r_if_ready;
  assign mem_ready_o = r_mem_ready;
  assign if_data_o   = r_if_data;
  assign mem_rdata_o = r_mem_rdata;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed bench: instance 0 uses round-robin arbitration, instance 1 fixed memory priority.
module tb_axi_rw_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 8;
  localparam int REQ_W  = 2 + AW + DW + SW;
  localparam int RESP_W = 2 + DW;

  logic clk;
  logic reset;

  logic          if_valid  [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_ready  [2];
  logic [DW-1:0] if_data   [2];
  logic          mem_valid [2];
  logic          mem_wen   [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [SW-1:0] mem_size  [2];
  logic          mem_ready [2];
  logic [DW-1:0] mem_rdata [2];
  logic          rw_valid  [2];
  logic          rw_req    [2];
  logic [AW-1:0] rw_addr   [2];
  logic [DW-1:0] rw_wdata  [2];
  logic [SW-1:0] rw_size   [2];
  logic          rw_ready  [2];
  logic [DW-1:0] rw_rdata  [2];
  logic [1:0]    dbg_state [2];

  logic [REQ_W-1:0]  req_q[$];
  logic [RESP_W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  bit hold   = 1'b0;
  int wcnt [2];
  logic [DW-1:0] prev_if  [2];
  logic [DW-1:0] prev_mem [2];
  bit rst_seen = 1'b1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_rw_arbiter #(
      .RW_DATA_WIDTH (DW),
      .RW_ADDR_WIDTH (AW),
      .RW_STRB_WIDTH (SW),
      .ROUND_ROBIN   ((g == 0) ? 1 : 0)
    ) u_dut (
      .clock          (clk),
      .reset          (reset),
      .if_valid_i     (if_valid[g]),
      .if_addr_i      (if_addr[g]),
      .if_ready_o     (if_ready[g]),
      .if_data_o      (if_data[g]),
      .mem_valid_i    (mem_valid[g]),
      .mem_wen_i      (mem_wen[g]),
      .mem_addr_i     (mem_addr[g]),
      .mem_wdata_i    (mem_wdata[g]),
      .mem_size_i     (mem_size[g]),
      .mem_ready_o    (mem_ready[g]),
      .mem_rdata_o    (mem_rdata[g]),
      .rw_valid_o     (rw_valid[g]),
      .rw_req_o       (rw_req[g]),
      .rw_addr_o      (rw_addr[g]),
      .rw_w_data_o    (rw_wdata[g]),
      .rw_size_o      (rw_size[g]),
      .rw_ready_i     (rw_ready[g]),
      .rw_data_read_i (rw_rdata[g]),
      .dbg_state_o    (dbg_state[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return {32'h0000_0013, a ^ 32'h8000_0093};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int g, input logic rq, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [SW-1:0] sz);
    req_q.push_back({1'(g), rq, a, wd, sz});
  endtask

  task automatic push_resp(input int g, input logic gr, input logic [DW-1:0] d);
    exp_q.push_back({1'(g), gr, d});
  endtask

  task automatic check_idle(input int g);
    chk("rst_state",    dbg_state[g], 2'd0);
    chk("rst_rw_valid", rw_valid[g], 1'b0);
    chk("rst_rw_req",   rw_req[g], 1'b0);
    chk("rst_rw_addr",  rw_addr[g], '0);
    chk("rst_rw_wdata", rw_wdata[g], '0);
    chk("rst_rw_size",  rw_size[g], '0);
    chk("rst_readies",  {if_ready[g], mem_ready[g]}, 2'b00);
    chk("rst_if_data",  if_data[g], '0);
    chk("rst_mem_data", mem_rdata[g], '0);
  endtask

  task automatic wait_ready(input int g, input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (if_ready[g] || mem_ready[g]) seen++;
    end
    chk("ready_count", seen, n);
  endtask

  // Counts negedges from the request drive slot to the ready pulse, then releases the request.
  task automatic run_one(input int g, input int exp_cyc);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      got = if_ready[g] || mem_ready[g];
    end
    chk("latency", cyc, exp_cyc);
    tick();
    if_valid[g]  = 1'b0;
    mem_valid[g] = 1'b0;
  endtask

  // ---------------- bridge model ----------------
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if (rw_ready[g]) begin
        rw_ready[g] = 1'b0;
      end else if (!rw_valid[g]) begin
        wcnt[g] = 0;
      end else if (!hold) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 1'b1, 1'b0);
        end else begin
          chk("req_fields", {1'(g), rw_req[g], rw_addr[g], rw_wdata[g], rw_size[g]}, req_q[0]);
        end
        if (wcnt[g] == lat) begin
          rw_rdata[g] = rd_of(rw_addr[g]);
          rw_ready[g] = 1'b1;
          wcnt[g] = 0;
          if (req_q.size() != 0) void'(req_q.pop_front());
        end else begin
          wcnt[g]++;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset && !rst_seen) begin
        if (if_ready[g] || mem_ready[g]) begin
          chk("ready_exclusive", if_ready[g] & mem_ready[g], 1'b0);
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 1'b1, 1'b0);
          end else begin
            chk("resp", {1'(g), mem_ready[g], mem_ready[g] ? mem_rdata[g] : if_data[g]},
                exp_q.pop_front());
          end
        end
        if (!if_ready[g])  chk("if_data_hold",  if_data[g],  prev_if[g]);
        if (!mem_ready[g]) chk("mem_data_hold", mem_rdata[g], prev_mem[g]);
      end
      prev_if[g]  = if_data[g];
      prev_mem[g] = mem_rdata[g];
    end
    rst_seen = reset;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if_valid[g] = 1'b0;  if_addr[g] = '0;
      mem_valid[g] = 1'b0; mem_wen[g] = 1'b0; mem_addr[g] = '0;
      mem_wdata[g] = '0;   mem_size[g] = '0;
      rw_ready[g] = 1'b0;  rw_rdata[g] = '0;  wcnt[g] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle(0);
    check_idle(1);
    tick();

    // Single fetch, bridge answers 3 cycles after rw_valid.
    lat = 3;
    push_req(0, 1'b0, 32'h8000_0000, 64'h0, 8'hFF);
    push_resp(0, 1'b0, 64'h0000_0013_0000_0093);
    if_addr[0] = 32'h8000_0000; if_valid[0] = 1'b1;
    run_one(0, 6);

    // Zero-wait bridge: ready two cycles after accept.
    lat = 0;
    push_req(0, 1'b0, 32'h8000_0008, 64'h0, 8'hFF);
    push_resp(0, 1'b0, 64'h0000_0013_0000_009b);
    if_addr[0] = 32'h8000_0008; if_valid[0] = 1'b1;
    run_one(0, 3);

    // Memory write.
    lat = 2;
    push_req(0, 1'b1, 32'h8000_1000, 64'hDEAD_BEEF, 8'h0F);
    push_resp(0, 1'b1, 64'h0000_0013_0000_1093);
    mem_wen[0] = 1'b1; mem_addr[0] = 32'h8000_1000;
    mem_wdata[0] = 64'hDEAD_BEEF; mem_size[0] = 8'h0F; mem_valid[0] = 1'b1;
    run_one(0, 5);

    // Address change after accept must not reach the bridge.
    lat = 3;
    push_req(0, 1'b0, 32'h0000_0100, 64'h1234, 8'h03);
    push_resp(0, 1'b1, rd_of(32'h0000_0100));
    mem_wen[0] = 1'b0; mem_addr[0] = 32'h0000_0100;
    mem_wdata[0] = 64'h1234; mem_size[0] = 8'h03; mem_valid[0] = 1'b1;
    tick();
    mem_addr[0] = 32'h0000_0200;
    wait_ready(0, 1);
    tick();
    mem_valid[0] = 1'b0;

    // Reset returns last_grant to fetch.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle(0);
    tick();

    // Round-robin conflict: MEM, IF, MEM, IF.
    lat = 1;
    for (int k = 0; k < 2; k++) begin
      push_req(0, 1'b0, 32'h8000_2000, 64'h0, 8'hFF);
      push_resp(0, 1'b1, rd_of(32'h8000_2000));
      push_req(0, 1'b0, 32'h8000_0100, 64'h0, 8'hFF);
      push_resp(0, 1'b0, rd_of(32'h8000_0100));
    end
    mem_wen[0] = 1'b0; mem_addr[0] = 32'h8000_2000; mem_wdata[0] = 64'h0;
    mem_size[0] = 8'hFF; if_addr[0] = 32'h8000_0100;
    mem_valid[0] = 1'b1; if_valid[0] = 1'b1;
    wait_ready(0, 4);
    tick();
    mem_valid[0] = 1'b0; if_valid[0] = 1'b0;

    // Fixed priority: three back-to-back memory reads before the held fetch.
    lat = 0;
    for (int k = 0; k < 3; k++) begin
      push_req(1, 1'b0, 32'h8000_3000 + 32'(8 * k), 64'h0, 8'h3C);
      push_resp(1, 1'b1, rd_of(32'h8000_3000 + 32'(8 * k)));
    end
    push_req(1, 1'b0, 32'h8000_0400, 64'h0, 8'hFF);
    push_resp(1, 1'b0, rd_of(32'h8000_0400));
    if_addr[1] = 32'h8000_0400; if_valid[1] = 1'b1;
    mem_wen[1] = 1'b0; mem_addr[1] = 32'h8000_3000; mem_size[1] = 8'h3C; mem_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready(1, 1);
      tick();
      if (k < 2) mem_addr[1] = mem_addr[1] + 32'd8;
      else       mem_valid[1] = 1'b0;
    end
    wait_ready(1, 1);
    tick();
    if_valid[1] = 1'b0;

    // Reset while BUSY with the bridge silent: no ready, everything cleared.
    hold = 1'b1;
    if_addr[0] = 32'h8000_0200; if_valid[0] = 1'b1;
    begin
      int cyc = 0;
      while (!rw_valid[0] && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("busy_reached", rw_valid[0], 1'b1);
    tick();
    reset = 1'b1; if_valid[0] = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle(0);
    hold = 1'b0;
    tick();

    // Fresh fetch after reset.
    lat = 0;
    push_req(0, 1'b0, 32'h8000_0010, 64'h0, 8'hFF);
    push_resp(0, 1'b0, rd_of(32'h8000_0010));
    if_addr[0] = 32'h8000_0010; if_valid[0] = 1'b1;
    run_one(0, 3);

    repeat (4) tick();
    chk("req_q_empty",  req_q.size(), 0);
    chk("resp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
